// File: rtl/alu_param_core_pkg.sv
// Shared types for the parametrised ALU core: op codes, operand-B select and FSM states.
package sv_alu_param_pkg;

  localparam int ALU_DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MULT = 4'd2,  OP_SHL  = 4'd3,
    OP_SHR  = 4'd4,  OP_ROL  = 4'd5,  OP_ROR  = 4'd6,  OP_NOT  = 4'd7,
    OP_AND  = 4'd8,  OP_OR   = 4'd9,  OP_XOR  = 4'd10, OP_NAND = 4'd11,
    OP_NOR  = 4'd12, OP_XNOR = 4'd13, OP_INC  = 4'd14, OP_DEC  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    MOVI_REG_B = 2'd0,
    MOVI_MEM   = 2'd1,
    MOVI_IMM   = 2'd2,
    MOVI_RSVD  = 2'd3
  } movi_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_param_core_mult.sv
// Iterative shift-add multiplier: consumes RADIX bits of B per cycle into a 2*DW accumulator.
// With ALU_FLAGS_EN defined it also reports whether the high half of the product is non-zero.
module alu_iter_mult #(
  parameter int DW    = 8,
  parameter int RADIX = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_done,
  output logic [DW-1:0] o_prod_lo
`ifdef ALU_FLAGS_EN
  ,
  output logic          o_hi_nz
`endif
);

  localparam int STEPS = DW / RADIX;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [2*DW-1:0] r_mcand;
  logic [2*DW-1:0] r_acc;
  logic [DW-1:0]   r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic [2*DW-1:0] w_partial;
  logic [2*DW-1:0] w_acc_nxt;
  logic            w_last;

  assign w_partial = r_mcand * {{(2*DW-RADIX){1'b0}}, r_mplier[RADIX-1:0]};
  assign w_acc_nxt = r_acc + w_partial;
  assign w_last    = (r_cnt == CW'(STEPS - 1));
  // done is asserted during the final step so the caller can register the result on the same edge
  assign o_done    = r_busy && w_last;
  assign o_prod_lo = w_acc_nxt[DW-1:0];
`ifdef ALU_FLAGS_EN
  assign o_hi_nz   = |w_acc_nxt[2*DW-1:DW];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{DW{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << RADIX;
      r_mplier <= r_mplier >> RADIX;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_param_core.sv
// Parametrised ALU core: operand-B mux, 16-op decode, registered result and multi-cycle MULT FSM.
// Optional ALU_FLAGS_EN adds the registered EX_FLAGS {ZERO,CARRY,OVF} port.
module alu_param_core
  import sv_alu_param_pkg::*;
#(
  parameter int DATA_WIDTH      = ALU_DATA_WIDTH,
  parameter int MULT_RADIX_BITS = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ACT,
  output logic                  ALU_RDY,
  input  logic [3:0]            OP,
  input  logic [1:0]            MOVI,
  input  logic [DATA_WIDTH-1:0] REG_A,
  input  logic [DATA_WIDTH-1:0] REG_B,
  input  logic [DATA_WIDTH-1:0] IMM,
  input  logic [DATA_WIDTH-1:0] MEM,
  output logic [DATA_WIDTH-1:0] EX_ALU,
  output logic                  EX_ALU_VLD
`ifdef ALU_FLAGS_EN
  ,
  output logic [2:0]            EX_FLAGS
`endif
);

  localparam int DW = DATA_WIDTH;

  if (DW % MULT_RADIX_BITS != 0) begin : g_radix_chk
    $error("DATA_WIDTH must be a multiple of MULT_RADIX_BITS");
  end
  if (DW < 4) begin : g_width_chk
    $error("DATA_WIDTH must be at least 4");
  end

  alu_op_t       w_op;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_opnd;
  logic [DW-1:0] w_res;
  logic          w_accept;
  logic          w_mult_done;
  logic [DW-1:0] w_mult_lo;
  alu_state_t    r_state;
  logic          r_rdy;
  logic [DW-1:0] r_res;
  logic          r_vld;

  assign w_op     = alu_op_t'(OP);
  assign w_accept = ACT && r_rdy;

  always_comb begin
    w_b = '0;
    case (movi_t'(MOVI))
      MOVI_REG_B: w_b = REG_B;
      MOVI_MEM:   w_b = MEM;
      MOVI_IMM:   w_b = IMM;
      default:    w_b = '0;
    endcase
  end

  // INC/DEC reuse the adder/subtractor with a constant one as the second operand
  assign w_opnd = (w_op == OP_INC || w_op == OP_DEC) ? {{(DW-1){1'b0}}, 1'b1} : w_b;

  always_comb begin
    w_res = '0;
    case (w_op)
      OP_ADD, OP_INC: w_res = REG_A + w_opnd;
      OP_SUB, OP_DEC: w_res = REG_A - w_opnd;
      OP_SHL:  w_res = {REG_A[DW-2:0], 1'b0};
      OP_SHR:  w_res = {1'b0, REG_A[DW-1:1]};
      OP_ROL:  w_res = {REG_A[DW-2:0], REG_A[DW-1]};
      OP_ROR:  w_res = {REG_A[0], REG_A[DW-1:1]};
      OP_NOT:  w_res = ~REG_A;
      OP_AND:  w_res = REG_A & w_b;
      OP_OR:   w_res = REG_A | w_b;
      OP_XOR:  w_res = REG_A ^ w_b;
      OP_NAND: w_res = ~(REG_A & w_b);
      OP_NOR:  w_res = ~(REG_A | w_b);
      OP_XNOR: w_res = ~(REG_A ^ w_b);
      default: w_res = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [DW:0] w_add_x;
  logic [DW:0] w_sub_x;
  logic        w_carry;
  logic        w_ovf;
  logic        w_mult_hi_nz;
  logic [2:0]  r_flags;

  always_comb begin
    w_add_x = {1'b0, REG_A} + {1'b0, w_opnd};
    w_sub_x = {1'b0, REG_A} - {1'b0, w_opnd};
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (w_op)
      OP_ADD, OP_INC: begin
        w_carry = w_add_x[DW];
        w_ovf   = (REG_A[DW-1] == w_opnd[DW-1]) && (w_add_x[DW-1] != REG_A[DW-1]);
      end
      OP_SUB, OP_DEC: begin
        w_carry = w_sub_x[DW];
        w_ovf   = (REG_A[DW-1] != w_opnd[DW-1]) && (w_sub_x[DW-1] != REG_A[DW-1]);
      end
      OP_SHL, OP_ROL: w_carry = REG_A[DW-1];
      OP_SHR, OP_ROR: w_carry = REG_A[0];
      default: ;
    endcase
  end

  assign EX_FLAGS = r_flags;
`endif

  alu_iter_mult #(
    .DW    (DW),
    .RADIX (MULT_RADIX_BITS)
  ) u_mult (
    .clk       (CLK),
    .rst_n     (RST),
    .i_start   (w_accept && (w_op == OP_MULT)),
    .i_a       (REG_A),
    .i_b       (w_b),
    .o_done    (w_mult_done),
    .o_prod_lo (w_mult_lo)
`ifdef ALU_FLAGS_EN
    ,
    .o_hi_nz   (w_mult_hi_nz)
`endif
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_rdy   <= 1'b1;
      r_res   <= '0;
      r_vld   <= 1'b0;
`ifdef ALU_FLAGS_EN
      r_flags <= '0;
`endif
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_op == OP_MULT) begin
              r_state <= ST_MULT;
              r_rdy   <= 1'b0;
            end else begin
              r_res <= w_res;
              r_vld <= 1'b1;
`ifdef ALU_FLAGS_EN
              r_flags <= {(w_res == '0), w_carry, w_ovf};
`endif
            end
          end
        end
        ST_MULT: begin
          if (w_mult_done) begin
            r_res   <= w_mult_lo;
            r_vld   <= 1'b1;
            r_state <= ST_DONE;
`ifdef ALU_FLAGS_EN
            r_flags <= {(w_mult_lo == '0), w_mult_hi_nz, 1'b0};
`endif
          end
        end
        // one cycle of recovery after the MULT result before new requests are taken
        ST_DONE: begin
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ALU_RDY    = r_rdy;
  assign EX_ALU     = r_res;
  assign EX_ALU_VLD = r_vld;

endmodule

// File: tb/tb_alu_param_core.sv
// Bench for alu_param_core (DW=8, radix 1): table vectors, MULT timing, mid-multiply reset, random ops.
module tb_alu_param_core;

  localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  MULT = 4'd2,  SHL = 4'd3,
                         SHR = 4'd4,  ROL = 4'd5,  ROR  = 4'd6,  NOT = 4'd7,
                         AND = 4'd8,  OR  = 4'd9,  XOR  = 4'd10, NAND = 4'd11,
                         NOR = 4'd12, XNOR = 4'd13, INC = 4'd14, DEC = 4'd15;

  typedef struct {
    logic [3:0] op;
    logic [1:0] movi;
    logic [7:0] a, rb, imm, mem;
    logic [7:0] er;
    logic [2:0] ef;
  } vec_t;

  typedef struct {
    logic [7:0] r;
    logic [2:0] f;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       ACT = 1'b0;
  logic [3:0] OP = '0;
  logic [1:0] MOVI = '0;
  logic [7:0] REG_A = '0, REG_B = '0, IMM = '0, MEM = '0;
  logic       ALU_RDY;
  logic [7:0] EX_ALU;
  logic       EX_ALU_VLD;
`ifdef ALU_FLAGS_EN
  logic [2:0] EX_FLAGS;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[20];

  alu_param_core #(.DATA_WIDTH(8), .MULT_RADIX_BITS(1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ACT        (ACT),
    .ALU_RDY    (ALU_RDY),
    .OP         (OP),
    .MOVI       (MOVI),
    .REG_A      (REG_A),
    .REG_B      (REG_B),
    .IMM        (IMM),
    .MEM        (MEM),
    .EX_ALU     (EX_ALU),
    .EX_ALU_VLD (EX_ALU_VLD)
`ifdef ALU_FLAGS_EN
    ,
    .EX_FLAGS   (EX_FLAGS)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] movi,
                              input logic [7:0] a, rb, imm, mem, er, input logic [2:0] ef);
    vec_t v;
    v.op = op; v.movi = movi; v.a = a; v.rb = rb; v.imm = imm; v.mem = mem;
    v.er = er; v.ef = ef;
    return v;
  endfunction

  function automatic logic [7:0] beff(input logic [1:0] movi, input logic [7:0] rb, imm, mem);
    case (movi)
      2'd0:    return rb;
      2'd1:    return mem;
      2'd2:    return imm;
      default: return 8'h00;
    endcase
  endfunction

  // reference model on plain integers: {result, Z, C, O}
  function automatic logic [10:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = a[7] ? ua - 256 : ua;
    int sb2 = b[7] ? ub - 256 : ub;
    int r = 0, c = 0, o = 0, s = 0;
    case (op)
      ADD:  begin s = ua + ub; r = s % 256; c = int'(s > 255); s = sa + sb2; o = int'(s > 127 || s < -128); end
      SUB:  begin s = ua - ub; r = (s + 256) % 256; c = int'(ua < ub); s = sa - sb2; o = int'(s > 127 || s < -128); end
      MULT: begin s = ua * ub; r = s % 256; c = int'(s > 255); end
      SHL:  begin r = (ua * 2) % 256; c = ua / 128; end
      SHR:  begin r = ua / 2; c = ua % 2; end
      ROL:  begin r = (ua * 2) % 256 + ua / 128; c = ua / 128; end
      ROR:  begin r = ua / 2 + (ua % 2) * 128; c = ua % 2; end
      NOT:  r = 255 - ua;
      AND:  r = ua & ub;
      OR:   r = ua | ub;
      XOR:  r = ua ^ ub;
      NAND: r = 255 - (ua & ub);
      NOR:  r = 255 - (ua | ub);
      XNOR: r = 255 - (ua ^ ub);
      INC:  begin s = ua + 1; r = s % 256; c = int'(s > 255); o = int'(sa + 1 > 127); end
      default: begin s = ua - 1; r = (s + 256) % 256; c = int'(ua == 0); o = int'(sa - 1 < -128); end
    endcase
    return {r[7:0], (r == 0), c[0], o[0]};
  endfunction

  task automatic wait_rdy(output bit ok);
    int n = 0;
    while (!ALU_RDY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    ok = ALU_RDY;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL rdy_timeout: ALU_RDY=%0b after %0d cycles, expected 1", ALU_RDY, n);
    end
  endtask

  task automatic apply(input vec_t v);
    bit ok;
    @(negedge CLK);
    wait_rdy(ok);
    if (ok) begin
      OP = v.op; MOVI = v.movi; REG_A = v.a; REG_B = v.rb; IMM = v.imm; MEM = v.mem;
      ACT = 1'b1;
      sb.push_back('{v.er, v.ef});
      @(posedge CLK);
      #1 ACT = 1'b0;
    end
  endtask

  always @(negedge CLK) begin
    if (RST && EX_ALU_VLD) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_vld: got EX_ALU=%0h, expected no result", EX_ALU);
      end else begin
        mon_e = sb.pop_front();
        chk("ex_alu", 32'(EX_ALU), 32'(mon_e.r));
`ifdef ALU_FLAGS_EN
        chk("ex_flags", 32'(EX_FLAGS), 32'(mon_e.f));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [10:0] m;
    logic [7:0]  b;
    vec_t        v;
    tbl[0]  = mk(ADD,  2'd0, 8'hFF, 8'h01, 8'h10, 8'h20, 8'h00, 3'b110);
    tbl[1]  = mk(SUB,  2'd1, 8'h00, 8'h55, 8'h77, 8'h01, 8'hFF, 3'b010);
    tbl[2]  = mk(ROR,  2'd0, 8'h01, 8'h33, 8'h00, 8'h00, 8'h80, 3'b010);
    tbl[3]  = mk(OR,   2'd3, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 3'b000);
    tbl[4]  = mk(DEC,  2'd0, 8'h80, 8'h05, 8'h00, 8'h00, 8'h7F, 3'b001);
    tbl[5]  = mk(INC,  2'd0, 8'h7F, 8'h09, 8'h00, 8'h00, 8'h80, 3'b001);
    tbl[6]  = mk(INC,  2'd2, 8'hFF, 8'h00, 8'h40, 8'h00, 8'h00, 3'b110);
    tbl[7]  = mk(SHL,  2'd0, 8'h81, 8'h00, 8'h00, 8'h00, 8'h02, 3'b010);
    tbl[8]  = mk(SHR,  2'd0, 8'h81, 8'h00, 8'h00, 8'h00, 8'h40, 3'b010);
    tbl[9]  = mk(ROL,  2'd0, 8'h81, 8'h00, 8'h00, 8'h00, 8'h03, 3'b010);
    tbl[10] = mk(NOT,  2'd0, 8'h00, 8'h12, 8'h00, 8'h00, 8'hFF, 3'b000);
    tbl[11] = mk(AND,  2'd2, 8'hF0, 8'h00, 8'h3C, 8'hFF, 8'h30, 3'b000);
    tbl[12] = mk(XOR,  2'd0, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h00, 3'b100);
    tbl[13] = mk(NAND, 2'd1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 3'b100);
    tbl[14] = mk(NOR,  2'd0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 3'b000);
    tbl[15] = mk(XNOR, 2'd0, 8'h0F, 8'hF0, 8'h0F, 8'h0F, 8'h00, 3'b100);
    tbl[16] = mk(ADD,  2'd2, 8'h7F, 8'h00, 8'h01, 8'h00, 8'h80, 3'b001);
    tbl[17] = mk(SUB,  2'd0, 8'h80, 8'h01, 8'h00, 8'h00, 8'h7F, 3'b001);
    tbl[18] = mk(MULT, 2'd0, 8'h10, 8'h10, 8'h03, 8'h05, 8'h00, 3'b110);
    tbl[19] = mk(MULT, 2'd1, 8'h0F, 8'h02, 8'h03, 8'h11, 8'hFF, 3'b000);

    // reset state
    #12;
    chk("rst_rdy", 32'(ALU_RDY), 32'd1);
    chk("rst_alu", 32'(EX_ALU), 32'd0);
    chk("rst_vld", 32'(EX_ALU_VLD), 32'd0);
`ifdef ALU_FLAGS_EN
    chk("rst_flags", 32'(EX_FLAGS), 32'd0);
`endif
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // MULT 0F*11 via IMM with ignored SUB requests and operand churn while busy
    @(negedge CLK);
    wait_rdy(ok);
    OP = MULT; MOVI = 2'd2; REG_A = 8'h0F; IMM = 8'h11; REG_B = 8'h00; ACT = 1'b1;
    sb.push_back('{8'hFF, 3'b000});
    @(posedge CLK);
    #1 ACT = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      chk($sformatf("mult_rdy_c%0d", k), 32'(ALU_RDY), 32'(k >= 10));
      chk($sformatf("mult_vld_c%0d", k), 32'(EX_ALU_VLD), 32'(k == 9));
      if (k >= 2 && k <= 8) begin
        ACT = 1'b1; OP = SUB; MOVI = 2'd0; REG_A = 8'h33; REG_B = 8'h11; IMM = 8'h01;
      end else begin
        ACT = 1'b0;
      end
    end
    chk("mult_hold", 32'(EX_ALU), 32'hFF);

    // reset in the middle of a multiply
    @(negedge CLK);
    wait_rdy(ok);
    OP = MULT; MOVI = 2'd0; REG_A = 8'h03; REG_B = 8'h05; ACT = 1'b1;
    @(posedge CLK);
    #1 ACT = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("midrst_rdy", 32'(ALU_RDY), 32'd1);
    chk("midrst_alu", 32'(EX_ALU), 32'd0);
    chk("midrst_vld", 32'(EX_ALU_VLD), 32'd0);
`ifdef ALU_FLAGS_EN
    chk("midrst_flags", 32'(EX_FLAGS), 32'd0);
`endif
    repeat (3) @(negedge CLK);
    chk("midrst_hold_vld", 32'(EX_ALU_VLD), 32'd0);
    RST = 1'b1;
    apply(mk(ADD, 2'd0, 8'h02, 8'h03, 8'h00, 8'h00, 8'h05, 3'b000));
    chk("postrst_vld_t1", 32'(EX_ALU_VLD), 32'd1);
    chk("postrst_alu_t1", 32'(EX_ALU), 32'h05);
    chk("postrst_rdy_t1", 32'(ALU_RDY), 32'd1);

    // random operations against the integer model
    for (int i = 0; i < 24; i++) begin
      v.op   = 4'($urandom_range(0, 15));
      v.movi = 2'($urandom_range(0, 3));
      v.a    = 8'($urandom_range(0, 255));
      v.rb   = 8'($urandom_range(0, 255));
      v.imm  = 8'($urandom_range(0, 255));
      v.mem  = 8'($urandom_range(0, 255));
      b      = beff(v.movi, v.rb, v.imm, v.mem);
      m      = model(v.op, v.a, b);
      v.er   = m[10:3];
      v.ef   = m[2:0];
      apply(v);
    end

    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge CLK);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
